// File: rtl/tetris_pkg.sv
// Shared types, VGA timing, board/score geometry and colour palette for the Tetris display path.
package tetris_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CNT_W    = 10;

    localparam int unsigned CELL_PX     = 20;
    localparam int unsigned BOARD_X0    = 220;
    localparam int unsigned BOARD_Y0    = 40;
    localparam int unsigned BORDER_PX   = 4;
    localparam int unsigned BOARD_COLS  = 10;
    localparam int unsigned BOARD_ROWS  = 20;
    localparam int unsigned BOARD_X1    = BOARD_X0 + CELL_PX * BOARD_COLS - 1;
    localparam int unsigned BOARD_Y1    = BOARD_Y0 + CELL_PX * BOARD_ROWS - 1;

    localparam int unsigned SCORE_BITS  = 16;
    localparam int unsigned SCORE_Y0    = 452;
    localparam int unsigned SCORE_SQ    = 8;
    localparam int unsigned SCORE_PITCH = 12;
    localparam int unsigned SCORE_X1    = BOARD_X0 + SCORE_PITCH * SCORE_BITS - 1;

    localparam int unsigned COLOR_W = 4;
    localparam int unsigned RGB_W   = 3 * COLOR_W;

    typedef logic [BOARD_ROWS-1:0][BOARD_COLS-1:0][COLOR_W-1:0] grid_t;
    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic [2:0] {
        REG_BLACK,
        REG_CELL,
        REG_GRIDLINE,
        REG_BORDER,
        REG_SCORE_ON,
        REG_SCORE_OFF
    } region_e;

    localparam rgb_t RGB_BLACK    = 12'h000;
    localparam rgb_t RGB_GRIDLINE = 12'h222;
    localparam rgb_t RGB_BORDER   = 12'h888;
    localparam rgb_t RGB_WHITE    = 12'hFFF;

    // Colour code to 12-bit RGB; codes above 7 render white.
    function automatic rgb_t palette(input logic [COLOR_W-1:0] code);
        rgb_t rgb;
        case (code)
            4'd0:    rgb = 12'h000;
            4'd1:    rgb = 12'h0FF;
            4'd2:    rgb = 12'hFF0;
            4'd3:    rgb = 12'hA0F;
            4'd4:    rgb = 12'hF80;
            4'd5:    rgb = 12'h00F;
            4'd6:    rgb = 12'h0F0;
            4'd7:    rgb = 12'hF00;
            default: rgb = 12'hFFF;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480 raster counters with raw syncs, active flag and frame markers; advances only on pixel strobe.
module vga_timing
    import tetris_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pix_en,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_hs_c,
    output logic             o_vs_c,
    output logic             o_active_c,
    output logic             o_line_end_c,
    output logic             o_vblank_start_c
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_pix_en) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
            end else begin
                r_h_cnt <= r_h_cnt + CNT_W'(1);
            end
        end
    end

    assign o_h_cnt          = r_h_cnt;
    assign o_v_cnt          = r_v_cnt;
    assign o_hs_c           = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
    assign o_vs_c           = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
    assign o_active_c       = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_line_end_c     = (r_h_cnt == H_LAST);
    assign o_vblank_start_c = i_pix_en && (r_h_cnt == '0) && (r_v_cnt == V_ACT);

endmodule

// File: rtl/tetris_vga_render.sv
// Renders the Tetris board, border and score bar to VGA from a per-frame snapshot of game state.
module tetris_vga_render
    import tetris_pkg::*;
(
    input  logic                  i_gm_clk,
    input  logic                  i_gm_rst,
    input  logic                  i_pix_en,
    input  grid_t                 i_grid,
    input  logic [SCORE_BITS-1:0] i_score,
    output logic                  o_vga_hs,
    output logic                  o_vga_vs,
    output logic [COLOR_W-1:0]    o_vga_r,
    output logic [COLOR_W-1:0]    o_vga_g,
    output logic [COLOR_W-1:0]    o_vga_b,
    output logic                  o_frame_tick
);

    localparam int unsigned SUB_W = $clog2(CELL_PX);
    localparam int unsigned COL_W = $clog2(BOARD_COLS);
    localparam int unsigned ROW_W = $clog2(BOARD_ROWS);
    localparam int unsigned SQ_W  = $clog2(SCORE_PITCH);
    localparam int unsigned IDX_W = $clog2(SCORE_BITS);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BOARD_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BOARD_ROWS - 1);
    localparam logic [SQ_W-1:0]  SQ_LAST  = SQ_W'(SCORE_PITCH - 1);
    localparam logic [SQ_W-1:0]  SQ_SIZE  = SQ_W'(SCORE_SQ);

    localparam logic [CNT_W-1:0] BX0    = CNT_W'(BOARD_X0);
    localparam logic [CNT_W-1:0] BX1    = CNT_W'(BOARD_X1);
    localparam logic [CNT_W-1:0] BY0    = CNT_W'(BOARD_Y0);
    localparam logic [CNT_W-1:0] BY1    = CNT_W'(BOARD_Y1);
    localparam logic [CNT_W-1:0] BX0_M1 = CNT_W'(BOARD_X0 - 1);
    localparam logic [CNT_W-1:0] BY0_M1 = CNT_W'(BOARD_Y0 - 1);
    localparam logic [CNT_W-1:0] FX0    = CNT_W'(BOARD_X0 - BORDER_PX);
    localparam logic [CNT_W-1:0] FX1    = CNT_W'(BOARD_X1 + BORDER_PX);
    localparam logic [CNT_W-1:0] FY0    = CNT_W'(BOARD_Y0 - BORDER_PX);
    localparam logic [CNT_W-1:0] FY1    = CNT_W'(BOARD_Y1 + BORDER_PX);
    localparam logic [CNT_W-1:0] SY0    = CNT_W'(SCORE_Y0);
    localparam logic [CNT_W-1:0] SY1    = CNT_W'(SCORE_Y0 + SCORE_SQ - 1);
    localparam logic [CNT_W-1:0] SX1    = CNT_W'(SCORE_X1);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_active;
    logic             w_line_end;
    logic             w_vblank_start;

    vga_timing u_timing (
        .i_clk            (i_gm_clk),
        .i_rst            (i_gm_rst),
        .i_pix_en         (i_pix_en),
        .o_h_cnt          (w_h_cnt),
        .o_v_cnt          (w_v_cnt),
        .o_hs_c           (w_hs_raw),
        .o_vs_c           (w_vs_raw),
        .o_active_c       (w_active),
        .o_line_end_c     (w_line_end),
        .o_vblank_start_c (w_vblank_start)
    );

    grid_t                 r_shadow_grid;
    logic [SCORE_BITS-1:0] r_shadow_score;
    logic                  r_frame_tick;

    // Frame-coherent snapshot of game state at the start of vertical blanking.
    always_ff @(posedge i_gm_clk or posedge i_gm_rst) begin
        if (i_gm_rst) begin
            r_shadow_grid  <= '0;
            r_shadow_score <= '0;
            r_frame_tick   <= 1'b0;
        end else begin
            r_frame_tick <= w_vblank_start;
            if (w_vblank_start) begin
                r_shadow_grid  <= i_grid;
                r_shadow_score <= i_score;
            end
        end
    end

    logic [SUB_W-1:0] r_sub_x;
    logic [SUB_W-1:0] r_sub_y;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [SQ_W-1:0]  r_sq_sub;
    logic [IDX_W-1:0] r_sq_idx;

    // Incremental cell/score-square addressing, aligned to the current counter values.
    always_ff @(posedge i_gm_clk or posedge i_gm_rst) begin
        if (i_gm_rst) begin
            r_sub_x  <= '0;
            r_sub_y  <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_sq_sub <= '0;
            r_sq_idx <= '0;
        end else if (i_pix_en) begin
            if (w_h_cnt == BX0_M1) begin
                r_sub_x  <= '0;
                r_col    <= '0;
                r_sq_sub <= '0;
                r_sq_idx <= '0;
            end else begin
                if (r_sub_x == SUB_LAST) begin
                    r_sub_x <= '0;
                    if (r_col != COL_LAST) r_col <= r_col + COL_W'(1);
                end else begin
                    r_sub_x <= r_sub_x + SUB_W'(1);
                end
                if (r_sq_sub == SQ_LAST) begin
                    r_sq_sub <= '0;
                    r_sq_idx <= r_sq_idx + IDX_W'(1);
                end else begin
                    r_sq_sub <= r_sq_sub + SQ_W'(1);
                end
            end
            if (w_line_end) begin
                if (w_v_cnt == BY0_M1) begin
                    r_sub_y <= '0;
                    r_row   <= '0;
                end else if (r_sub_y == SUB_LAST) begin
                    r_sub_y <= '0;
                    if (r_row != ROW_LAST) r_row <= r_row + ROW_W'(1);
                end else begin
                    r_sub_y <= r_sub_y + SUB_W'(1);
                end
            end
        end
    end

    region_e              w_region;
    logic [COLOR_W-1:0]   w_cell_code;
    logic                 w_in_board;
    logic                 w_in_frame;
    logic                 w_in_score;

    assign w_cell_code = r_shadow_grid[r_row][r_col];
    assign w_in_board  = (w_h_cnt >= BX0) && (w_h_cnt <= BX1) && (w_v_cnt >= BY0) && (w_v_cnt <= BY1);
    assign w_in_frame  = (w_h_cnt >= FX0) && (w_h_cnt <= FX1) && (w_v_cnt >= FY0) && (w_v_cnt <= FY1);
    assign w_in_score  = (w_v_cnt >= SY0) && (w_v_cnt <= SY1) && (w_h_cnt >= BX0) && (w_h_cnt <= SX1)
                         && (r_sq_sub < SQ_SIZE);

    // Region priority; square 0 is the MSB, so the bit index is the inverted square index.
    always_comb begin
        w_region = REG_BLACK;
        if (!w_active) begin
            w_region = REG_BLACK;
        end else if (w_in_board) begin
            w_region = ((r_sub_x == SUB_LAST) || (r_sub_y == SUB_LAST)) ? REG_GRIDLINE : REG_CELL;
        end else if (w_in_frame) begin
            w_region = REG_BORDER;
        end else if (w_in_score) begin
            w_region = r_shadow_score[~r_sq_idx] ? REG_SCORE_ON : REG_SCORE_OFF;
        end
    end

    region_e            r_region_s1;
    logic [COLOR_W-1:0] r_code_s1;
    logic               r_valid_s1;
    logic               r_hs_s1;
    logic               r_vs_s1;
    rgb_t               w_rgb;
    rgb_t               r_rgb;
    logic               r_hs_s2;
    logic               r_vs_s2;

    always_comb begin
        w_rgb = RGB_BLACK;
        case (r_region_s1)
            REG_CELL:      w_rgb = palette(r_code_s1);
            REG_GRIDLINE:  w_rgb = RGB_GRIDLINE;
            REG_BORDER:    w_rgb = RGB_BORDER;
            REG_SCORE_ON:  w_rgb = RGB_WHITE;
            REG_SCORE_OFF: w_rgb = RGB_GRIDLINE;
            default:       w_rgb = RGB_BLACK;
        endcase
    end

    // S1 decode/lookup and S2 palette stages; syncs ride alongside to stay aligned.
    always_ff @(posedge i_gm_clk or posedge i_gm_rst) begin
        if (i_gm_rst) begin
            r_region_s1 <= REG_BLACK;
            r_code_s1   <= '0;
            r_valid_s1  <= 1'b0;
            r_hs_s1     <= 1'b1;
            r_vs_s1     <= 1'b1;
            r_rgb       <= '0;
            r_hs_s2     <= 1'b1;
            r_vs_s2     <= 1'b1;
        end else if (i_pix_en) begin
            r_region_s1 <= w_region;
            r_code_s1   <= w_cell_code;
            r_valid_s1  <= 1'b1;
            r_hs_s1     <= w_hs_raw;
            r_vs_s1     <= w_vs_raw;
            r_rgb       <= r_valid_s1 ? w_rgb : RGB_BLACK;
            r_hs_s2     <= r_hs_s1;
            r_vs_s2     <= r_vs_s1;
        end
    end

    assign o_vga_hs     = r_hs_s2;
    assign o_vga_vs     = r_vs_s2;
    assign o_vga_r      = r_rgb[RGB_W-1 -: COLOR_W];
    assign o_vga_g      = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign o_vga_b      = r_rgb[COLOR_W-1 -: COLOR_W];
    assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_tetris_vga_render.sv
// Directed bench for tetris_vga_render: sync timing, snapshot/tearing, region colours, frame tick, reset.
module tb_tetris_vga_render;
    import tetris_pkg::*;

    localparam longint LINE  = 800;
    localparam longint FRAME = 420000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    grid_t       grid;
    logic [15:0] score;
    logic        vga_hs, vga_vs, frame_tick;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [11:0] rgb;

    int     checks = 0;
    int     errors = 0;
    longint pcount;
    int     n_ticks = 0;
    bit     fast = 1'b0;
    bit [1:0] div = 2'd0;

    tetris_vga_render dut (
        .i_gm_clk     (clk),
        .i_gm_rst     (rst),
        .i_pix_en     (pix_en),
        .i_grid       (grid),
        .i_score      (score),
        .o_vga_hs     (vga_hs),
        .o_vga_vs     (vga_vs),
        .o_vga_r      (vga_r),
        .o_vga_g      (vga_g),
        .o_vga_b      (vga_b),
        .o_frame_tick (frame_tick)
    );

    assign rgb = {vga_r, vga_g, vga_b};

    always #5 clk = ~clk;

    // Pixel strobe: 1 in 4, or every cycle when fast is set to shorten whole-frame waits.
    initial begin
        pix_en = 1'b0;
        forever begin
            @(negedge clk);
            div    = div + 2'd1;
            pix_en = fast || (div == 2'd0);
        end
    end

    // Reference pixel position: number of strobes since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) pcount <= 0;
        else if (pix_en) pcount <= pcount + 1;
    end

    always @(posedge clk) begin
        if (frame_tick) n_ticks <= n_ticks + 1;
    end

    task automatic wait_pc(input longint t);
        int guard = 0;
        while (pcount < t && guard < 3000000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (pcount != t) begin
            errors++;
            $display("FAIL wait_pc reached %0d required %0d", pcount, t);
        end
    endtask

    task automatic wait_hs(input logic lvl, output longint p);
        int guard = 0;
        while (vga_hs !== lvl && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        p = pcount;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        grid  = '0;
        grid[0][0]  = 4'd1;
        grid[19][9] = 4'd9;
        score = 16'h8001;
        repeat (3) @(negedge clk);
        checks++;
        if (vga_hs !== 1'b1) begin errors++; $display("FAIL rst_hs got %b exp 1", vga_hs); end
        checks++;
        if (vga_vs !== 1'b1) begin errors++; $display("FAIL rst_vs got %b exp 1", vga_vs); end
        checks++;
        if (rgb !== 12'h000) begin errors++; $display("FAIL rst_rgb got %h exp 000", rgb); end
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b exp 0", frame_tick); end
        rst = 1'b0;
    endtask

    task automatic test_hsync;
        longint p1, p2, p3;
        wait_hs(1'b0, p1);
        checks++;
        if (p1 != 658) begin errors++; $display("FAIL hs_fall got %0d exp 658", p1); end
        wait_hs(1'b1, p2);
        checks++;
        if (p2 - p1 != 96) begin errors++; $display("FAIL hs_width got %0d exp 96", p2 - p1); end
        wait_hs(1'b0, p3);
        checks++;
        if (p3 - p1 != LINE) begin errors++; $display("FAIL line_period got %0d exp 800", p3 - p1); end
    endtask

    task automatic test_frame_timing;
        longint vs_pc[4]  = '{392001, 392002, 393601, 393602};
        logic   vs_exp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        wait_pc(384001);
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick1 got %b exp 1", frame_tick); end
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick1_width got %b exp 0", frame_tick); end
        checks++;
        if (n_ticks != 1) begin errors++; $display("FAIL tick_count1 got %0d exp 1", n_ticks); end
        for (int i = 0; i < 4; i++) begin
            wait_pc(vs_pc[i]);
            checks++;
            if (vga_vs !== vs_exp[i]) begin
                errors++;
                $display("FAIL vs_at_%0d got %b exp %b", vs_pc[i], vga_vs, vs_exp[i]);
            end
        end
    endtask

    task automatic test_frame1;
        int          xa[5]  = '{216, 220, 239, 240, 320};
        int          ya[5]  = '{36, 40, 40, 40, 140};
        logic [11:0] ea[5]  = '{12'h888, 12'h0FF, 12'h222, 12'h000, 12'h000};
        int          xb[7]  = '{400, 420, 220, 232, 400, 404, 408};
        int          yb[7]  = '{420, 420, 452, 452, 452, 452, 452};
        logic [11:0] eb[7]  = '{12'hFFF, 12'h888, 12'hFFF, 12'h222, 12'hFFF, 12'hFFF, 12'h000};
        for (int i = 0; i < 5; i++) begin
            wait_pc(FRAME + longint'(ya[i]) * LINE + longint'(xa[i]) + 2);
            checks++;
            if (rgb !== ea[i]) begin
                errors++;
                $display("FAIL f1_px(%0d,%0d) got %h exp %h", xa[i], ya[i], rgb, ea[i]);
            end
        end
        // Mid-frame edit at line 200: must not appear until the next frame.
        wait_pc(FRAME + 200 * LINE);
        grid[0][0]  = 4'd0;
        grid[5][5]  = 4'd4;
        grid[19][9] = 4'd2;
        for (int i = 0; i < 7; i++) begin
            wait_pc(FRAME + longint'(yb[i]) * LINE + longint'(xb[i]) + 2);
            checks++;
            if (rgb !== eb[i]) begin
                errors++;
                $display("FAIL f1_px(%0d,%0d) got %h exp %h", xb[i], yb[i], rgb, eb[i]);
            end
        end
    endtask

    task automatic test_frame2;
        int          xs[3] = '{220, 320, 339};
        int          ys[3] = '{40, 140, 159};
        logic [11:0] es[3] = '{12'h000, 12'hF80, 12'h222};
        wait_pc(FRAME + 384001);
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick2 got %b exp 1", frame_tick); end
        @(negedge clk);
        checks++;
        if (n_ticks != 2) begin errors++; $display("FAIL tick_count2 got %0d exp 2", n_ticks); end
        for (int i = 0; i < 3; i++) begin
            wait_pc(2 * FRAME + longint'(ys[i]) * LINE + longint'(xs[i]) + 2);
            checks++;
            if (rgb !== es[i]) begin
                errors++;
                $display("FAIL f2_px(%0d,%0d) got %h exp %h", xs[i], ys[i], rgb, es[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        longint p;
        wait_pc(2 * FRAME + 300 * LINE + 216 + 2);
        checks++;
        if (rgb !== 12'h888) begin errors++; $display("FAIL pre_rst_px(216,300) got %h exp 888", rgb); end
        checks++;
        if (n_ticks != 2) begin errors++; $display("FAIL tick_count_pre_rst got %0d exp 2", n_ticks); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (vga_hs !== 1'b1) begin errors++; $display("FAIL mid_rst_hs got %b exp 1", vga_hs); end
        checks++;
        if (vga_vs !== 1'b1) begin errors++; $display("FAIL mid_rst_vs got %b exp 1", vga_vs); end
        checks++;
        if (rgb !== 12'h000) begin errors++; $display("FAIL mid_rst_rgb got %h exp 000", rgb); end
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick got %b exp 0", frame_tick); end
        repeat (3) @(negedge clk);
        fast = 1'b0;
        rst  = 1'b0;
        wait_hs(1'b0, p);
        checks++;
        if (p != 658) begin errors++; $display("FAIL post_rst_hs_fall got %0d exp 658", p); end
    endtask

    initial begin
        test_reset();
        test_hsync();
        fast = 1'b1;
        test_frame_timing();
        test_frame1();
        test_frame2();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
